// File: rtl/tick_gen_bank_pkg.sv
// Shared constants and types for the tick generator bank.
// Holds the clock-domain divisor constants used by the clock design and the
// per-channel operating mode used inside each channel.
package tick_gen_bank_pkg;

    // System clock and the standard divisors derived from it
    localparam int CLK_HZ   = 50_000_000;
    localparam int DIV_1HZ  = 50_000_000;
    localparam int DIV_1KHZ = 50_000;
    localparam int DIV_SCAN = 16_384;

    // Default bank shape: ch0 = 1 Hz, ch1 = 1 kHz, ch2 = display scan
    localparam int DEF_NUM_CH = 3;
    localparam int DEF_CNT_W  = 32;
    localparam int DEF_CH_W   = 3;
    localparam logic [DEF_NUM_CH*DEF_CNT_W-1:0] DEF_DIV_INIT =
        {32'(DIV_SCAN), 32'(DIV_1KHZ), 32'(DIV_1HZ)};

    // Channel operating mode, decoded each cycle from divisor and run enable
    typedef enum logic [1:0] {
        CH_OFF  = 2'd0,   // active divisor is 0: channel parked at phase 0
        CH_HOLD = 2'd1,   // global run low: counter and square wave frozen
        CH_RUN  = 2'd2    // counting toward terminal count
    } ch_mode_e;

endpackage

// File: rtl/tick_channel.sv
// One divider channel: phase counter, active/shadow divisor and outputs.
// A new divisor waits in the shadow register and is swapped in only at the
// terminal-count edge (or at once when the channel is off or frozen), so the
// tick spacing never shows a partial period.
module tick_channel
    import tick_gen_bank_pkg::*;
#(
    parameter int               CNT_W   = DEF_CNT_W,
    parameter logic [CNT_W-1:0] DIV_RST = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync_clr,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    output logic             tick,
    output logic             sq,
    output logic             pending
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] act_div;
    logic [CNT_W-1:0] shadow;
    ch_mode_e         mode;
    logic             term;
    logic             apply;

    // Decode the channel mode from the active divisor and run enable
    always_comb begin
        mode = CH_RUN;
        if (act_div == '0) begin
            mode = CH_OFF;
        end else if (!en) begin
            mode = CH_HOLD;
        end
    end

    assign term  = (mode == CH_RUN) && (cnt == act_div - CNT_W'(1));
    // Swap in a waiting divisor at terminal count, or straight away when the
    // channel has no running phase to protect
    assign apply = pending && (term || (mode != CH_RUN));

    // Divisor bookkeeping: active divisor, shadow and pending flag.
    // A write cannot land while pending is set (the port stalls it), so a
    // write and an apply never coincide; a write on a terminal edge therefore
    // waits for the following terminal count.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_div <= DIV_RST;
            shadow  <= '0;
            pending <= 1'b0;
        end else if (sync_clr) begin
            pending <= 1'b0;
            if (wr) begin
                act_div <= wr_div;
            end else if (pending) begin
                act_div <= shadow;
            end
        end else if (apply) begin
            act_div <= shadow;
            pending <= 1'b0;
        end else if (wr) begin
            shadow  <= wr_div;
            pending <= 1'b1;
        end
    end

    // Phase counter, tick pulse and square wave
    always_ff @(posedge clk) begin
        if (rst || sync_clr) begin
            cnt  <= '0;
            tick <= 1'b0;
            sq   <= 1'b0;
        end else begin
            case (mode)
                CH_OFF: begin
                    cnt  <= '0;
                    tick <= 1'b0;
                    sq   <= 1'b0;
                end
                CH_HOLD: begin
                    tick <= 1'b0;
                    if (apply) begin
                        cnt <= '0;
                    end
                end
                CH_RUN: begin
                    if (term) begin
                        cnt  <= '0;
                        tick <= 1'b1;
                        sq   <= ~sq;
                    end else begin
                        cnt  <= cnt + CNT_W'(1);
                        tick <= 1'b0;
                    end
                end
                default: begin
                    cnt  <= '0;
                    tick <= 1'b0;
                    sq   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/tick_gen_bank.sv
// Multi-channel tick / clock-enable generator.
// Each channel divides clk by its own run-time divisor and produces a one-cycle
// tick plus a 50% square wave. The top level decodes the single divisor write
// port, steers it to one channel and flags writes to nonexistent channels.
//
// Write port handshake: a write transfers on a clk edge where cfg_valid and
// cfg_ready are both 1. cfg_ready is low while the addressed channel still holds
// an unapplied divisor, and during reset; it is high for out-of-range channels,
// which are accepted and answered with a one-cycle cfg_err instead of a state
// change. cfg_ready does not depend on cfg_valid.
module tick_gen_bank
    import tick_gen_bank_pkg::*;
#(
    parameter int                        NUM_CH   = DEF_NUM_CH,
    parameter int                        CNT_W    = DEF_CNT_W,
    parameter int                        CH_W     = DEF_CH_W,
    parameter logic [NUM_CH*CNT_W-1:0]   DIV_INIT = DEF_DIV_INIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              sync_clr,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] sq,
    output logic [NUM_CH-1:0] pending
);

    localparam logic [CH_W:0] NUM_CH_L = (CH_W+1)'(NUM_CH);

    logic              ch_in_range;
    logic              pend_sel;
    logic              cfg_acc;
    logic [NUM_CH-1:0] ch_wr;

    assign ch_in_range = ({1'b0, cfg_ch} < NUM_CH_L);

    // Pending flag of the addressed channel; 0 when the channel does not exist
    always_comb begin
        pend_sel = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                pend_sel = pending[i];
            end
        end
    end

    assign cfg_ready = ~rst & ~pend_sel;
    assign cfg_acc   = cfg_valid & cfg_ready;

    // Steer an accepted write to exactly one existing channel
    always_comb begin
        ch_wr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_wr[i] = cfg_acc && (cfg_ch == CH_W'(i));
        end
    end

    // One-cycle error pulse for an accepted write to a nonexistent channel
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_acc & ~ch_in_range;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        tick_channel #(
            .CNT_W   (CNT_W),
            .DIV_RST (DIV_INIT[g*CNT_W +: CNT_W])
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .sync_clr (sync_clr),
            .wr       (ch_wr[g]),
            .wr_div   (cfg_div),
            .tick     (tick[g]),
            .sq       (sq[g]),
            .pending  (pending[g])
        );
    end

endmodule

// File: tb/tb_tick_gen_bank.sv
// Bench for tick_gen_bank: a vector table for the power-up sequence, directed
// sequences for the multi-cycle corners, and randomized traffic checked
// against a divisor/phase reference model.
module tb_tick_gen_bank;

    localparam int NCH   = 3;
    localparam int CNT_W = 8;
    localparam int CH_W  = 3;

    logic             clk;
    logic             rst;
    logic             en;
    logic             sync_clr;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_err;
    logic [NCH-1:0]   tick;
    logic [NCH-1:0]   sq;
    logic [NCH-1:0]   pending;

    tick_gen_bank #(
        .NUM_CH   (NCH),
        .CNT_W    (CNT_W),
        .CH_W     (CH_W),
        .DIV_INIT ({8'd5, 8'd3, 8'd1})
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .sync_clr  (sync_clr),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_err   (cfg_err),
        .tick      (tick),
        .sq        (sq),
        .pending   (pending)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    // ---------------- reference model ----------------
    // Each channel: divisor, shadow divisor, enabled edges since its phase
    // origin. A tick is due whenever that edge count is a multiple of the divisor.
    int             m_init[NCH] = '{1, 3, 5};
    int             m_div[NCH];
    int             m_shadow[NCH];
    int             m_ph[NCH];
    logic [NCH-1:0] m_tick = '0;
    logic [NCH-1:0] m_sq   = '0;
    logic [NCH-1:0] m_pend = '0;
    logic           m_err  = 1'b0;

    function automatic logic model_ready(input int r, input int ch);
        logic busy;
        busy = 1'b0;
        if (ch < NCH) busy = m_pend[ch];
        return (r == 0) && !busy;
    endfunction

    task automatic model_edge(input int r, e, sc, v, ch, dv);
        logic acc;
        logic hit;
        int   old;
        acc = (v != 0) && model_ready(r, ch);
        if (r != 0) begin
            for (int c = 0; c < NCH; c++) begin
                m_div[c] = m_init[c]; m_shadow[c] = 0; m_ph[c] = 0;
            end
            m_tick = '0; m_sq = '0; m_pend = '0; m_err = 1'b0;
        end else begin
            m_err = acc && (ch >= NCH);
            for (int c = 0; c < NCH; c++) begin
                if (sc != 0) begin
                    m_ph[c] = 0; m_tick[c] = 1'b0; m_sq[c] = 1'b0;
                    if (acc && ch == c) m_div[c] = dv;
                    else if (m_pend[c]) m_div[c] = m_shadow[c];
                    m_pend[c] = 1'b0;
                end else begin
                    old = m_div[c];
                    hit = 1'b0;
                    if (old == 0) begin
                        m_tick[c] = 1'b0; m_sq[c] = 1'b0; m_ph[c] = 0;
                    end else if (e != 0) begin
                        m_ph[c]++;
                        hit = ((m_ph[c] % old) == 0);
                        m_tick[c] = hit;
                        if (hit) m_sq[c] = ~m_sq[c];
                    end else begin
                        m_tick[c] = 1'b0;
                    end
                    if (m_pend[c] && (hit || old == 0 || e == 0)) begin
                        m_div[c] = m_shadow[c]; m_pend[c] = 1'b0; m_ph[c] = 0;
                    end else if (acc && ch == c) begin
                        m_shadow[c] = dv; m_pend[c] = 1'b1;
                    end
                end
            end
        end
    endtask

    // ---------------- driver: one clock cycle, checked against the model ----------------
    task automatic step(input int r, e, sc, v, ch, dv);
        logic exp_rdy;
        rst       = (r != 0);
        en        = (e != 0);
        sync_clr  = (sc != 0);
        cfg_valid = (v != 0);
        cfg_ch    = CH_W'(ch);
        cfg_div   = CNT_W'(dv);
        exp_rdy   = model_ready(r, ch);
        #1;
        chk("cfg_ready", 32'(cfg_ready), 32'(exp_rdy));
        model_edge(r, e, sc, v, ch, dv);
        @(posedge clk);
        #1;
        cyc++;
        chk("tick", 32'(tick), 32'(m_tick));
        chk("sq", 32'(sq), 32'(m_sq));
        chk("pending", 32'(pending), 32'(m_pend));
        chk("cfg_err", 32'(cfg_err), 32'(m_err));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int         r;
        int         e;
        int         v;
        int         ch;
        int         dv;
        logic [2:0] t;
        logic [2:0] s;
        logic [2:0] p;
        logic       er;
    } vec_t;

    vec_t            vecs[18];
    logic [7:0]      exp_q[$];
    int              first[NCH];
    int              cnt2;
    logic [NCH-1:0]  sq_hold;

    initial begin
        // Power-up with divisors {ch2=5, ch1=3, ch0=1}, then freeze, resume
        // and an out-of-range write.
        vecs[0]  = '{1, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 1'b0};
        vecs[1]  = '{0, 1, 0, 0, 0, 3'b001, 3'b001, 3'b000, 1'b0};
        vecs[2]  = '{0, 1, 0, 0, 0, 3'b001, 3'b000, 3'b000, 1'b0};
        vecs[3]  = '{0, 1, 0, 0, 0, 3'b011, 3'b011, 3'b000, 1'b0};
        vecs[4]  = '{0, 1, 0, 0, 0, 3'b001, 3'b010, 3'b000, 1'b0};
        vecs[5]  = '{0, 1, 0, 0, 0, 3'b101, 3'b111, 3'b000, 1'b0};
        vecs[6]  = '{0, 1, 0, 0, 0, 3'b011, 3'b100, 3'b000, 1'b0};
        vecs[7]  = '{0, 1, 0, 0, 0, 3'b001, 3'b101, 3'b000, 1'b0};
        vecs[8]  = '{0, 1, 0, 0, 0, 3'b001, 3'b100, 3'b000, 1'b0};
        vecs[9]  = '{0, 1, 0, 0, 0, 3'b011, 3'b111, 3'b000, 1'b0};
        vecs[10] = '{0, 1, 0, 0, 0, 3'b101, 3'b010, 3'b000, 1'b0};
        vecs[11] = '{0, 0, 0, 0, 0, 3'b000, 3'b010, 3'b000, 1'b0};
        vecs[12] = '{0, 0, 0, 0, 0, 3'b000, 3'b010, 3'b000, 1'b0};
        vecs[13] = '{0, 1, 0, 0, 0, 3'b001, 3'b011, 3'b000, 1'b0};
        vecs[14] = '{0, 1, 0, 0, 0, 3'b011, 3'b000, 3'b000, 1'b0};
        vecs[15] = '{0, 1, 1, 5, 9, 3'b001, 3'b001, 3'b000, 1'b1};
        vecs[16] = '{0, 1, 0, 0, 0, 3'b001, 3'b000, 3'b000, 1'b0};
        vecs[17] = '{0, 1, 0, 0, 0, 3'b111, 3'b111, 3'b000, 1'b0};

        rst = 1'b1; en = 1'b0; sync_clr = 1'b0; cfg_valid = 1'b0;
        cfg_ch = '0; cfg_div = '0;

        for (int i = 0; i < 18; i++) begin
            step(vecs[i].r, vecs[i].e, 0, vecs[i].v, vecs[i].ch, vecs[i].dv);
            chk("vec_tick", 32'(tick), 32'(vecs[i].t));
            chk("vec_sq", 32'(sq), 32'(vecs[i].s));
            chk("vec_pending", 32'(pending), 32'(vecs[i].p));
            chk("vec_cfg_err", 32'(cfg_err), 32'(vecs[i].er));
        end

        // ch1 running div 3, write 7 while its count is 1: one tick on the old
        // phase, then 7-cycle spacing.
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);          // edge 1
        step(0, 1, 0, 1, 1, 7);          // edge 2: write accepted
        chk("t2_pending", 32'(pending[1]), 32'd1);
        chk("t2_ready_low", 32'(cfg_ready), 32'd0);
        exp_q = {8'd3, 8'd10, 8'd17};
        for (int k = 3; k <= 18; k++) begin
            step(0, 1, 0, 0, 1, 0);
            if (k == 3) chk("t2_pending_clear", 32'(pending[1]), 32'd0);
            if (tick[1]) begin
                if (exp_q.size() == 0) chk("t2_extra_tick", 32'(k), 32'd0);
                else chk("t2_tick_edge", 32'(k), 32'(exp_q.pop_front()));
            end
        end
        chk("t2_missing_ticks", 32'(exp_q.size()), 32'd0);

        // ch2 switched off, then given div 4
        step(0, 1, 0, 1, 2, 0);
        for (int k = 0; k < 10; k++) step(0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 0, 0, 0, 0);
            chk("t3_off_tick", 32'(tick[2]), 32'd0);
            chk("t3_off_sq", 32'(sq[2]), 32'd0);
        end
        step(0, 1, 0, 1, 2, 4);
        first[0] = 0;
        for (int n = 1; n <= 12; n++) begin
            step(0, 1, 0, 0, 0, 0);
            if (tick[2] && first[0] == 0) first[0] = n;
        end
        chk("t3_first_tick", 32'(first[0]), 32'd5);

        // sync clear from scattered phases with a ch0 write on the same edge
        for (int k = 0; k < 7; k++) step(0, ($urandom_range(0, 1) == 1) ? 1 : 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 0, 2);
        chk("t4_tick_clr", 32'(tick), 32'd0);
        chk("t4_sq_clr", 32'(sq), 32'd0);
        for (int c = 0; c < NCH; c++) first[c] = 0;
        for (int n = 1; n <= 10; n++) begin
            step(0, 1, 0, 0, 0, 0);
            for (int c = 0; c < NCH; c++) if (tick[c] && first[c] == 0) first[c] = n;
        end
        chk("t4_ch0_first", 32'(first[0]), 32'd2);
        chk("t4_ch1_first", 32'(first[1]), 32'd7);
        chk("t4_ch2_first", 32'(first[2]), 32'd4);

        // freeze for 10 cycles; a write lands while frozen and reset follows it
        sq_hold = sq;
        for (int k = 0; k < 10; k++) begin
            if (k == 4) step(0, 0, 0, 1, 2, 9);
            else if (k == 5) step(1, 0, 0, 0, 0, 0);
            else step(0, 0, 0, 0, 0, 0);
            chk("t5_no_tick", 32'(tick), 32'd0);
            if (k < 4) chk("t5_sq_frozen", 32'(sq), 32'(sq_hold));
            if (k == 4) chk("t5_pending", 32'(pending[2]), 32'd1);
            if (k == 5) begin
                chk("t5_rst_pending", 32'(pending), 32'd0);
                chk("t5_rst_sq", 32'(sq), 32'd0);
            end
        end
        step(0, 1, 0, 0, 0, 0);
        chk("t5_ch0_div1", 32'(tick[0]), 32'd1);
        for (int k = 0; k < 5; k++) step(0, 1, 0, 0, 0, 0);

        // write to channel 5 of 3
        step(0, 1, 0, 1, 5, 9);
        chk("t6_err_pulse", 32'(cfg_err), 32'd1);
        chk("t6_no_pending", 32'(pending), 32'd0);
        step(0, 1, 0, 0, 0, 0);
        chk("t6_err_clear", 32'(cfg_err), 32'd0);

        // largest divisor for an 8-bit counter
        step(0, 1, 0, 1, 2, 255);
        cnt2 = 0;
        for (int n = 1; n <= 520; n++) begin
            step(0, 1, 0, 0, 0, 0);
            if (n >= 11 && tick[2]) cnt2++;
        end
        chk("wrap_ticks", 32'(cnt2), 32'd2);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            int r, e, sc, v, ch, dv;
            r  = ($urandom_range(0, 99) == 0) ? 1 : 0;
            e  = ($urandom_range(0, 9) != 0) ? 1 : 0;
            sc = ($urandom_range(0, 39) == 0) ? 1 : 0;
            v  = ($urandom_range(0, 3) == 0) ? 1 : 0;
            ch = int'($urandom_range(0, 7));
            dv = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(2, 9));
            step(r, e, sc, v, ch, dv);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
